wca_expansion_pattern_gen: RTL and testbench

Programmable 3-bit pattern sequencer that sits directly upstream of the expansion-port output latch. It stores up to 16 three-bit patterns and plays entries 0..len in order, one step per dwell interval, in one-shot or loop mode. It presents each new pattern on `ep_data` with a single-cycle `ep_strobe`. `ep_data` feeds the latch's `epin`, `ep_strobe` feeds `ctrl1`, and the host-level port-enable drives `ctrl2`.

---
 rtl/wca_expansion_pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_wca_expansion_pattern_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wca_expansion_pattern_gen.sv
// wca_expansion_pattern_gen
// Programmable 3-bit pattern sequencer feeding the expansion-port output latch.
// Holds up to 16 three-bit patterns and plays entries 0..len in order, one
// step per dwell interval, in one-shot or loop mode. Each new pattern appears
// on ep_data together with a single-cycle ep_strobe.
// Step timing: 1 LOAD cycle plus dwell+1 DWELL cycles, so the step period is
// dwell+2 cycles and the first strobe comes 2 cycles after start is sampled.

module wca_expansion_pattern_gen #(
    parameter int DEPTH  = 16,
    parameter int DWELLW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [2:0]        wr_data,
    input  logic [3:0]        len,
    input  logic [DWELLW-1:0] dwell,
    input  logic              loop,
    input  logic              start,
    input  logic              stop,
    output logic [2:0]        ep_data,
    output logic              ep_strobe,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    // Sequencer state
    state_t              state_r;
    state_t              next_state_s;
    logic                busy_r;

    // Run parameters captured when a run is launched
    logic [3:0]          len_sh_r;
    logic [DWELLW-1:0]   dwell_sh_r;
    logic                loop_sh_r;

    // Position within the pattern and dwell countdown
    logic [3:0]          idx_r;
    logic [DWELLW-1:0]   cnt_r;

    // Pattern storage
    logic [2:0]          mem_r [DEPTH];

    // Output registers
    logic [2:0]          ep_data_r;
    logic                ep_strobe_r;
    logic                done_r;

    // Decoded actions for this cycle
    logic                launch_s;
    logic                step_s;
    logic                wrap_s;
    logic                finish_s;
    logic                load_fire_s;
    logic                cnt_zero_s;

    assign cnt_zero_s = (cnt_r == {DWELLW{1'b0}});

    // Next-state decode; stop overrides everything, including a start in IDLE
    always_comb begin
        next_state_s = state_r;
        launch_s     = 1'b0;
        step_s       = 1'b0;
        wrap_s       = 1'b0;
        finish_s     = 1'b0;
        load_fire_s  = 1'b0;
        if (stop) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        next_state_s = ST_LOAD;
                        launch_s     = 1'b1;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    next_state_s = ST_DWELL;
                    load_fire_s  = 1'b1;
                end
                ST_DWELL: begin
                    if (cnt_zero_s) begin
                        if (idx_r != len_sh_r) begin
                            next_state_s = ST_LOAD;
                            step_s       = 1'b1;
                        end else if (loop_sh_r) begin
                            next_state_s = ST_LOAD;
                            wrap_s       = 1'b1;
                        end else begin
                            next_state_s = ST_IDLE;
                            finish_s     = 1'b1;
                        end
                    end else begin
                        next_state_s = ST_DWELL;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register; busy is registered alongside so it tracks state exactly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != ST_IDLE);
        end
    end

    // Capture run parameters only when a run launches, so mid-run changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_sh_r   <= 4'd0;
            dwell_sh_r <= {DWELLW{1'b0}};
            loop_sh_r  <= 1'b0;
        end else if (launch_s) begin
            len_sh_r   <= len;
            dwell_sh_r <= dwell;
            loop_sh_r  <= loop;
        end else begin
            len_sh_r   <= len_sh_r;
            dwell_sh_r <= dwell_sh_r;
            loop_sh_r  <= loop_sh_r;
        end
    end

    // Entry index: cleared at launch and on loop wrap, advanced between entries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r <= 4'd0;
        end else if (launch_s || wrap_s) begin
            idx_r <= 4'd0;
        end else if (step_s) begin
            idx_r <= idx_r + 4'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Dwell countdown: reloaded on leaving LOAD, only ever decrements so it cannot overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {DWELLW{1'b0}};
        end else if (load_fire_s) begin
            cnt_r <= dwell_sh_r;
        end else if ((state_r == ST_DWELL) && !cnt_zero_s) begin
            cnt_r <= cnt_r - {{(DWELLW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Pattern memory write port; reads elsewhere see the pre-write contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 3'd0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Output latch feed: pattern and strobe on LOAD exit, done on one-shot completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ep_data_r   <= 3'd0;
            ep_strobe_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            ep_strobe_r <= load_fire_s;
            done_r      <= finish_s;
            if (load_fire_s) begin
                ep_data_r <= mem_r[idx_r];
            end else begin
                ep_data_r <= ep_data_r;
            end
        end
    end

    assign ep_data   = ep_data_r;
    assign ep_strobe = ep_strobe_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_wca_expansion_pattern_gen.sv
// Bench for wca_expansion_pattern_gen: a cycle-indexed behavioural model
// (step position derived from elapsed cycles since start) checked every cycle,
// plus directed literal checks from hand-computed schedules.

module tb_wca_expansion_pattern_gen;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_addr = 4'd0;
    logic [2:0]    wr_data = 3'd0;
    logic [3:0]    len = 4'd0;
    logic [DW-1:0] dwell = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [2:0]    ep_data;
    logic          ep_strobe;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    wca_expansion_pattern_gen #(.DEPTH(16), .DWELLW(DW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .len(len), .dwell(dwell), .loop(loop),
        .start(start), .stop(stop), .ep_data(ep_data), .ep_strobe(ep_strobe),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act_v, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_data = 3'(d);
        tick();
        wr_en = 1'b0;
    endtask

    // Behavioural model: outputs follow from elapsed cycles since the start cycle
    logic [2:0] mmem [16];
    bit         run_on;
    int         rs, rl, rd, mc;
    bit         rlp;
    logic [2:0] e_data;
    bit         e_strobe, e_busy, e_done;

    initial begin
        int e, p, tot;
        e_data = 3'd0; e_strobe = 0; e_busy = 0; e_done = 0;
        run_on = 0; mc = 0; rs = 0; rl = 0; rd = 0; rlp = 0;
        for (int i = 0; i < 16; i++) mmem[i] = 3'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                e_data = 3'd0; e_strobe = 0; e_busy = 0; e_done = 0;
            end
            chk("m_strobe", int'(ep_strobe), int'(e_strobe));
            chk("m_data",   int'(ep_data),   int'(e_data));
            chk("m_busy",   int'(busy),      int'(e_busy));
            chk("m_done",   int'(done),      int'(e_done));
            if (reset) begin
                run_on = 0;
                for (int i = 0; i < 16; i++) mmem[i] = 3'd0;
            end else begin
                if (stop) begin
                    run_on = 0; e_strobe = 0; e_done = 0; e_busy = 0;
                end else if (!run_on) begin
                    e_strobe = 0; e_done = 0;
                    if (start) begin
                        run_on = 1; rs = mc; rl = int'(len); rd = int'(dwell); rlp = loop;
                        e_busy = 1;
                    end else begin
                        e_busy = 0;
                    end
                end else begin
                    e = mc + 1 - rs;
                    p = rd + 2;
                    tot = 2 + (rl + 1) * p - 1;
                    if (!rlp && e == tot) begin
                        run_on = 0; e_done = 1; e_busy = 0; e_strobe = 0;
                    end else begin
                        e_done = 0; e_busy = 1;
                        e_strobe = (e >= 2) && (((e - 2) % p) == 0);
                        if (e_strobe) e_data = mmem[((e - 2) / p) % (rl + 1)];
                    end
                end
                if (wr_en) mmem[wr_addr] = wr_data;
            end
            mc++;
        end
    end

    // Directed stimulus with literal expectations
    initial begin
        int nstr, ndone;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_data", int'(ep_data), 0);
        chk("rst_busy", int'(busy), 0);

        // One-shot: 1,2,4,7 with dwell 2
        wr(0, 1); wr(1, 2); wr(2, 4); wr(3, 7);
        len = 4'd3; dwell = 16'd2; loop = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        chk("t1_busy_c1", int'(busy), 1);
        chk("t1_strb_c1", int'(ep_strobe), 0);
        nstr = 0;
        for (int c = 2; c <= 18; c++) begin
            tick();
            if (ep_strobe) nstr++;
            case (c)
                2:  begin chk("t1_s0", int'(ep_strobe), 1); chk("t1_d0", int'(ep_data), 1); end
                6:  begin chk("t1_s1", int'(ep_strobe), 1); chk("t1_d1", int'(ep_data), 2); end
                10: begin chk("t1_s2", int'(ep_strobe), 1); chk("t1_d2", int'(ep_data), 4); end
                14: begin chk("t1_s3", int'(ep_strobe), 1); chk("t1_d3", int'(ep_data), 7); end
                16: begin chk("t1_busy16", int'(busy), 1); chk("t1_done16", int'(done), 0); end
                17: begin chk("t1_done17", int'(done), 1); chk("t1_busy17", int'(busy), 0); end
                18: begin chk("t1_done18", int'(done), 0); chk("t1_hold", int'(ep_data), 7); end
                default: ;
            endcase
        end
        chk("t1_nstrobe", nstr, 4);

        // Loop len=0 dwell=0: strobe every 2nd cycle
        wr(0, 5);
        len = 4'd0; dwell = 16'd0; loop = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        ndone = 0;
        for (int c = 2; c <= 21; c++) begin
            tick();
            if (done) ndone++;
            if (c <= 5) chk("t2_strobe", int'(ep_strobe), (c % 2 == 0) ? 1 : 0);
        end
        chk("t2_data", int'(ep_data), 5);
        chk("t2_ndone", ndone, 0);
        stop = 1'b1;
        tick(); stop = 1'b0;
        chk("t2_stop_busy", int'(busy), 0);
        chk("t2_stop_strb", int'(ep_strobe), 0);

        // Stop mid-run after the 2nd strobe
        wr(0, 3); wr(1, 5); wr(2, 6); wr(3, 1);
        len = 4'd3; dwell = 16'd3; loop = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (c == 2) chk("t3_d0", int'(ep_data), 3);
            if (c == 7) begin chk("t3_s1", int'(ep_strobe), 1); chk("t3_d1", int'(ep_data), 5); end
        end
        stop = 1'b1;
        tick(); stop = 1'b0;
        chk("t3_busy", int'(busy), 0);
        chk("t3_hold", int'(ep_data), 5);
        nstr = 0; ndone = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ep_strobe) nstr++;
            if (done) ndone++;
        end
        chk("t3_nstrobe", nstr, 0);
        chk("t3_ndone", ndone, 0);

        // Start and stop together in IDLE
        len = 4'd1; dwell = 16'd5; loop = 1'b0; start = 1'b1; stop = 1'b1;
        tick(); start = 1'b0; stop = 1'b0;
        chk("t4_busy", int'(busy), 0);
        tick();
        chk("t4_busy2", int'(busy), 0);
        chk("t4_strb", int'(ep_strobe), 0);

        // Write entry 1 in the cycle it is loaded
        wr(0, 2); wr(1, 3);
        len = 4'd1; dwell = 16'd1; loop = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 2; c <= 11; c++) begin
            tick();
            wr_en = 1'b0;
            if (c == 4) begin wr_en = 1'b1; wr_addr = 4'd1; wr_data = 3'd6; end
            if (c == 5)  chk("t5_old", int'(ep_data), 3);
            if (c == 8)  chk("t5_e0", int'(ep_data), 2);
            if (c == 11) begin chk("t5_new", int'(ep_data), 6); chk("t5_s", int'(ep_strobe), 1); end
        end
        wr_en = 1'b0;
        stop = 1'b1;
        tick(); stop = 1'b0;

        // Asynchronous reset mid-DWELL
        len = 4'd3; dwell = 16'd4; loop = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("t6_pre", int'(ep_data), 2);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("t6_data", int'(ep_data), 0);
        chk("t6_strb", int'(ep_strobe), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        tick();
        reset = 1'b0;
        tick();
        len = 4'd3; dwell = 16'd0; loop = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (c % 2 == 0 && c <= 8) begin
                chk("t6_s", int'(ep_strobe), 1);
                chk("t6_zero", int'(ep_data), 0);
            end
            if (c == 9) chk("t6_done9", int'(done), 1);
        end
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
